// File: rtl/phasemeter_lock_sequencer.sv
// Sweep/acquire/lock supervisor for one phasemeter channel: steps the NCO guess,
// pulses the phasemeter reset, detects a beat note on |I|+|Q| and supervises lock.
module phasemeter_lock_sequencer #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int ACCUM_WIDTH      = 32,
    parameter int CIC_OUTPUT_WIDTH = 14,
    parameter int F_START          = 0,
    parameter int F_STEP           = 1048576,
    parameter int F_STOP           = 16777216,
    parameter int DWELL            = 256,
    parameter int RST_LEN          = 4,
    parameter int AMP_THRESH       = 2048,
    parameter int DETECT_COUNT     = 4,
    parameter int SETTLE           = 1024,
    parameter int UNLOCK_COUNT     = 16,
    parameter int MAX_PASSES       = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_LPF_tdata,
    input  logic                        S_AXIS_LPF_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_QUAD_tdata,
    input  logic                        S_AXIS_QUAD_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_GUESS_tdata,
    output logic                        M_AXIS_GUESS_tvalid,
    output logic                        pm_rst,
    output logic                        pm_en,
    output logic                        locked,
    output logic                        lost_lock,
    output logic                        fail,
    output logic [2:0]                  state
);
    localparam int CW  = CIC_OUTPUT_WIDTH;
    localparam int AW  = CIC_OUTPUT_WIDTH + 1;
    localparam int GW1 = ACCUM_WIDTH + 1;
    localparam int TW  = $clog2((RST_LEN > SETTLE ? RST_LEN : SETTLE) + 1);
    localparam int SW  = $clog2(DWELL + 1);
    localparam int RW  = $clog2((DETECT_COUNT > UNLOCK_COUNT ? DETECT_COUNT : UNLOCK_COUNT) + 1);
    localparam int PW  = $clog2(MAX_PASSES + 1);

    localparam logic [ACCUM_WIDTH-1:0] START_G = ACCUM_WIDTH'(F_START);
    localparam logic [GW1-1:0]         STEP_G  = GW1'(F_STEP);
    localparam logic [GW1-1:0]         STOP_G  = GW1'(F_STOP);
    localparam logic [AW-1:0]          THRESH  = AW'(AMP_THRESH);
    localparam logic [CW-1:0]          MOST_NEG = {1'b1, {(CW-1){1'b0}}};
    localparam logic [CW-1:0]          MOST_POS = {1'b0, {(CW-1){1'b1}}};
    localparam logic [TW-1:0]          RST_LAST    = TW'(RST_LEN - 1);
    localparam logic [TW-1:0]          SETTLE_LAST = TW'(SETTLE - 1);
    localparam logic [SW-1:0]          DWELL_LAST  = SW'(DWELL - 1);
    localparam logic [RW-1:0]          DETECT_LAST = RW'(DETECT_COUNT - 1);
    localparam logic [RW-1:0]          UNLOCK_LAST = RW'(UNLOCK_COUNT - 1);
    localparam logic [PW-1:0]          PASS_LIMIT  = PW'(MAX_PASSES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LOAD = 3'd1, S_DWELL = 3'd2, S_ENGAGE = 3'd3,
        S_SETTLE = 3'd4, S_LOCKED = 3'd5, S_FAIL = 3'd6
    } state_t;

    state_t                  cur, next;
    logic [ACCUM_WIDTH-1:0]  guess, guess_d;
    logic [PW-1:0]           passes, passes_d, passes_inc;
    logic                    lost_d;
    logic [TW-1:0]           timer, timer_d;
    logic [SW-1:0]           samples, samples_d;
    logic [RW-1:0]           run, run_d;
    logic                    do_step;
    logic [GW1-1:0]          step_sum;

    logic signed [CW-1:0]    i_word, q_word;
    logic [AW-1:0]           amp, amp_next;
    logic                    amp_vld, sample, above;
    logic                    unused_low;

    function automatic logic [CW-1:0] abs_sat(input logic signed [CW-1:0] x);
        if (!x[CW-1]) return x;
        return (x == MOST_NEG) ? MOST_POS : -x;
    endfunction

    assign i_word     = S_AXIS_LPF_tdata[AXIS_TDATA_WIDTH-1 -: CW];
    assign q_word     = S_AXIS_QUAD_tdata[AXIS_TDATA_WIDTH-1 -: CW];
    assign unused_low = ^{S_AXIS_LPF_tdata[AXIS_TDATA_WIDTH-CW-1:0],
                          S_AXIS_QUAD_tdata[AXIS_TDATA_WIDTH-CW-1:0]};
    assign sample     = S_AXIS_LPF_tvalid && S_AXIS_QUAD_tvalid;
    assign amp_next   = {1'b0, abs_sat(i_word)} + {1'b0, abs_sat(q_word)};
    // amp holds the most recent qualified sample; amp_vld marks the cycle it is fresh.
    assign above      = (amp >= THRESH);
    assign step_sum   = {1'b0, guess} + STEP_G;
    assign passes_inc = passes + 1'b1;

    assign state              = cur;
    assign M_AXIS_GUESS_tdata = AXIS_TDATA_WIDTH'(guess);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        next      = cur;
        guess_d   = guess;
        passes_d  = passes;
        lost_d    = lost_lock;
        timer_d   = timer;
        samples_d = samples;
        run_d     = run;
        do_step   = 1'b0;
        case (cur)
            S_IDLE, S_FAIL: if (start) begin
                guess_d  = START_G;
                passes_d = '0;
                lost_d   = 1'b0;
                next     = S_LOAD;
            end
            S_LOAD: begin
                timer_d = timer + 1'b1;
                if (timer == RST_LAST) next = S_DWELL;
            end
            S_DWELL: if (amp_vld) begin
                run_d     = above ? run + 1'b1 : '0;
                samples_d = samples + 1'b1;
                if (above && run == DETECT_LAST) next = S_ENGAGE;
                else if (samples == DWELL_LAST) do_step = 1'b1;
            end
            S_ENGAGE: next = S_SETTLE;
            S_SETTLE: begin
                timer_d = timer + 1'b1;
                if (timer == SETTLE_LAST) begin
                    if (above) next = S_LOCKED;
                    else do_step = 1'b1;
                end
            end
            S_LOCKED: if (amp_vld) begin
                run_d = above ? '0 : run + 1'b1;
                if (!above && run == UNLOCK_LAST) begin
                    lost_d = 1'b1;
                    next   = S_LOAD;
                end
            end
            default: next = S_IDLE;
        endcase

        // Past the top of the band the sweep wraps and a full pass is counted.
        if (do_step) begin
            if (step_sum > STOP_G) begin
                guess_d  = START_G;
                passes_d = passes_inc;
                next     = (passes_inc == PASS_LIMIT) ? S_FAIL : S_LOAD;
            end else begin
                guess_d = step_sum[ACCUM_WIDTH-1:0];
                next    = S_LOAD;
            end
        end

        if (abort) begin
            next     = S_IDLE;
            guess_d  = guess;
            passes_d = passes;
            lost_d   = lost_lock;
        end

        if (next != cur) begin
            timer_d   = '0;
            samples_d = '0;
            run_d     = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur                 <= S_IDLE;
            guess               <= START_G;
            passes              <= '0;
            lost_lock           <= 1'b0;
            timer               <= '0;
            samples             <= '0;
            run                 <= '0;
            amp                 <= '0;
            amp_vld             <= 1'b0;
            M_AXIS_GUESS_tvalid <= 1'b0;
            pm_rst              <= 1'b0;
            pm_en               <= 1'b0;
            locked              <= 1'b0;
            fail                <= 1'b0;
        end else begin
            cur                 <= next;
            guess               <= guess_d;
            passes              <= passes_d;
            lost_lock           <= lost_d;
            timer               <= timer_d;
            samples             <= samples_d;
            run                 <= run_d;
            amp_vld             <= sample;
            if (sample) amp     <= amp_next;
            M_AXIS_GUESS_tvalid <= 1'b1;
            // Outputs decode the next state so they change on the same edge as the state.
            pm_rst              <= (next == S_LOAD);
            pm_en               <= (next == S_ENGAGE) || (next == S_SETTLE) || (next == S_LOCKED);
            locked              <= (next == S_LOCKED);
            fail                <= (next == S_FAIL);
        end
    end
endmodule

// File: tb/tb_phasemeter_lock_sequencer.sv
// Scoreboard bench: a sweep-level model queues the expected reload/lock/fail events,
// a monitor pops them as the DUT produces them; a reactive source plays a beat note.
module tb_phasemeter_lock_sequencer;
    localparam int W = 32, CW = 14;
    localparam int F_START = 1000, F_STEP = 100, F_STOP = 1300, MAX_PASSES = 2;
    localparam int DWELL = 8, RST_LEN = 4, AMP_THRESH = 2048, DETECT_COUNT = 4;
    localparam int SETTLE = 32, UNLOCK_COUNT = 16;

    logic         clk = 1'b0;
    logic         rst, start, abort;
    logic [W-1:0] lpf_tdata, quad_tdata, guess_out;
    logic         lpf_tvalid, quad_tvalid, guess_tvalid;
    logic         pm_rst, pm_en, locked, lost_lock, fail;
    logic [2:0]   state;

    phasemeter_lock_sequencer #(
        .AXIS_TDATA_WIDTH(W), .ACCUM_WIDTH(32), .CIC_OUTPUT_WIDTH(CW),
        .F_START(F_START), .F_STEP(F_STEP), .F_STOP(F_STOP), .DWELL(DWELL),
        .RST_LEN(RST_LEN), .AMP_THRESH(AMP_THRESH), .DETECT_COUNT(DETECT_COUNT),
        .SETTLE(SETTLE), .UNLOCK_COUNT(UNLOCK_COUNT), .MAX_PASSES(MAX_PASSES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .S_AXIS_LPF_tdata(lpf_tdata), .S_AXIS_LPF_tvalid(lpf_tvalid),
        .S_AXIS_QUAD_tdata(quad_tdata), .S_AXIS_QUAD_tvalid(quad_tvalid),
        .M_AXIS_GUESS_tdata(guess_out), .M_AXIS_GUESS_tvalid(guess_tvalid),
        .pm_rst(pm_rst), .pm_en(pm_en), .locked(locked), .lost_lock(lost_lock),
        .fail(fail), .state(state)
    );

    always #5 clk = ~clk;

    typedef enum int { EV_LOAD = 0, EV_LOCK = 1, EV_FAIL = 2 } ev_kind_t;
    typedef struct { ev_kind_t kind; int guess; bit lost; } ev_t;
    ev_t exp_q[$];

    int checks = 0, fails = 0;
    int target = -1;
    int quiet_left = 0;
    bit kill_settle = 0, sat_mode = 0, mon_en = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Sweep-level reference: which guesses get loaded, and where it locks or gives up.
    function automatic void model_sweep(int tgt, bit kill);
        int g = F_START;
        int passes = 0;
        while (1) begin
            exp_q.push_back('{kind: EV_LOAD, guess: g, lost: 1'b0});
            if (g == tgt && !kill) begin
                exp_q.push_back('{kind: EV_LOCK, guess: g, lost: 1'b0});
                return;
            end
            if (g + F_STEP > F_STOP) begin
                g = F_START;
                passes++;
                if (passes == MAX_PASSES) begin
                    exp_q.push_back('{kind: EV_FAIL, guess: F_START, lost: 1'b0});
                    return;
                end
            end else begin
                g += F_STEP;
            end
        end
    endfunction

    // Beat-note source: a tone above threshold only while the guess sits on the target.
    always @(negedge clk) begin : source
        int r, a, b;
        bit vi, vq, tone;
        logic [CW-1:0] iw, qw;
        r    = $urandom_range(0, 9);
        vi   = (r <= 7);
        vq   = (r <= 6) || (r == 8);
        tone = (int'(guess_out) == target) && (quiet_left == 0) && !(kill_settle && state == 3'd4);
        if (tone) begin
            if ($urandom_range(0, 7) == 0) begin a = 2048; b = 0; end
            else begin a = $urandom_range(1024, 8191); b = $urandom_range(1024, 8191); end
        end else begin
            if ($urandom_range(0, 7) == 0) begin a = 2047; b = 0; end
            else begin a = $urandom_range(0, 1000); b = $urandom_range(0, 1000); end
        end
        iw = CW'(a);
        qw = CW'(b);
        if ($urandom_range(0, 1) == 1) iw = -iw;
        if ($urandom_range(0, 1) == 1) qw = -qw;
        if (sat_mode) begin
            iw = 14'h2000; qw = 14'h2000; vi = 1'b1; vq = 1'b1;
        end
        lpf_tdata   = {iw, 18'($urandom)};
        quad_tdata  = {qw, 18'($urandom)};
        lpf_tvalid  = vi;
        quad_tvalid = vq;
        if (vi && vq && quiet_left > 0) quiet_left--;
    end

    task automatic got(input ev_kind_t k);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_event: got kind %0d guess %0d, expected no event", k, guess_out);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", k, e.kind);
        check("event_guess", guess_out, e.guess);
        case (k)
            EV_LOAD: begin
                check("load_lost_lock", lost_lock, e.lost);
                check("load_pm_en", pm_en, 0);
            end
            EV_LOCK: begin
                check("lock_pm_en", pm_en, 1);
                check("lock_state", state, 5);
            end
            default: begin
                check("fail_state", state, 6);
                check("fail_pm_en", pm_en, 0);
            end
        endcase
    endtask

    bit prev_rst = 0, prev_locked = 0, prev_fail = 0;
    int rst_run = 0;
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (pm_rst && !prev_rst) got(EV_LOAD);
            if (locked && !prev_locked) got(EV_LOCK);
            if (fail && !prev_fail) got(EV_FAIL);
            if (pm_rst) rst_run++;
            else if (prev_rst) begin
                check("pm_rst_width", rst_run, RST_LEN);
                rst_run = 0;
            end
        end else begin
            rst_run = 0;
        end
        prev_rst    = pm_rst;
        prev_locked = locked;
        prev_fail   = fail;
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1;
        check("start_to_pm_rst", pm_rst, 1);
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL %s_timeout: %0d events pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk) #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_guess"}, guess_out, F_START);
        check({tag, "_tvalid"}, guess_tvalid, 0);
        check({tag, "_pm_rst"}, pm_rst, 0);
        check({tag, "_pm_en"}, pm_en, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_lost_lock"}, lost_lock, 0);
        check({tag, "_fail"}, fail, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_values("reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
        check("tvalid_after_reset", guess_tvalid, 1);
        check("idle_without_start", state, 0);

        // Saturated magnitude: both words at the most negative 14-bit value.
        sat_mode = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("amp_saturation", dut.amp, 16382);
        @(negedge clk) sat_mode = 1'b0;

        // Full sweep with no beat note: two passes then FAIL.
        mon_en = 1'b1;
        target = -1;
        model_sweep(-1, 1'b0);
        pulse_start();
        wait_drain("sweep_fail", 4000);
        check("sweep_fail_state", state, 6);
        check("sweep_fail_flag", fail, 1);

        // Acquire a randomly placed beat note, restarting from FAIL.
        target = F_START + F_STEP * $urandom_range(0, 3);
        model_sweep(target, 1'b0);
        pulse_start();
        wait_drain("acquire", 4000);
        check("acquire_locked", locked, 1);
        check("acquire_guess", guess_out, target);
        check("acquire_fail_clear", fail, 0);

        // Fades shorter than the unlock count must not drop lock.
        for (int t = 0; t < 3; t++) begin
            quiet_left = (t == 0) ? UNLOCK_COUNT - 1 : $urandom_range(1, UNLOCK_COUNT - 1);
            n = 0;
            while (quiet_left != 0 && n < 500) begin @(posedge clk); n++; end
            repeat (10) @(posedge clk);
            #1 check("short_fade_locked", locked, 1);
            check("short_fade_state", state, 5);
        end

        // A fade of exactly the unlock count: reload at the same guess, then relock.
        exp_q.push_back('{kind: EV_LOAD, guess: target, lost: 1'b1});
        exp_q.push_back('{kind: EV_LOCK, guess: target, lost: 1'b1});
        quiet_left = UNLOCK_COUNT;
        wait_drain("lock_loss", 2000);
        check("lost_lock_sticky", lost_lock, 1);

        // Abort out of LOCKED holds the guess.
        @(negedge clk) abort = 1'b1;
        @(posedge clk) #1;
        check("abort_locked_state", state, 0);
        check("abort_locked_pm_en", pm_en, 0);
        check("abort_locked_guess", guess_out, target);
        @(negedge clk) abort = 1'b0;

        // Beat note disappears during SETTLE every time: sweep continues to FAIL.
        kill_settle = 1'b1;
        target = F_START + F_STEP * $urandom_range(0, 3);
        model_sweep(target, 1'b1);
        pulse_start();
        wait_drain("settle_fail", 6000);
        check("settle_fail_state", state, 6);
        check("settle_fail_lost_cleared", lost_lock, 0);
        kill_settle = 1'b0;

        // Abort in the second LOAD cycle, then start and abort together.
        mon_en = 1'b0;
        target = -1;
        pulse_start();
        abort = 1'b1;
        @(posedge clk) #1;
        check("abort_load_state", state, 0);
        check("abort_load_pm_rst", pm_rst, 0);
        check("abort_load_guess", guess_out, F_START);
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(posedge clk) #1;
        check("start_abort_state", state, 0);
        check("start_abort_pm_rst", pm_rst, 0);
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end

        // Asynchronous reset while locked.
        mon_en = 1'b1;
        target = F_START + F_STEP * $urandom_range(0, 3);
        model_sweep(target, 1'b0);
        pulse_start();
        wait_drain("relock", 4000);
        check("relock_locked", locked, 1);
        #1 rst = 1'b1;
        #1 check_reset_values("async_reset");
        @(negedge clk) rst = 1'b0;
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
